// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, phase length and ID matching.
package sccb_pkg;

    // One SCCB phase is 8 data bits plus one don't-care bit.
    localparam int         PHASE_LEN    = 9;
    localparam logic [3:0] LAST_BIT_CNT = 4'(PHASE_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ID      = 4'd1,
        ST_ID_X    = 4'd2,
        ST_SUB     = 4'd3,
        ST_SUB_X   = 4'd4,
        ST_WDATA   = 4'd5,
        ST_WDATA_X = 4'd6,
        ST_RDATA   = 4'd7,
        ST_RDATA_X = 4'd8,
        ST_IGNORE  = 4'd9
    } sccb_state_t;

    // Bit 0 of an ID byte is the direction bit; only [7:1] select the device.
    function automatic logic id_match(input logic [7:0] rx_id, input logic [7:0] dev_id);
        return rx_id[7:1] == dev_id[7:1];
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Brings SIO_C/SIO_D into the XCLK domain and reports edges of the synchronized lines.
module sccb_line_sync (
    input  logic XCLK,
    input  logic RST_N,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_h;
    logic       sda_h;

    // Reset to 1 so an idle bus does not look like an edge after reset.
    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl};
            sda_ff <= {sda_ff[0], sda};
            scl_h  <= scl_ff[1];
            sda_h  <= sda_ff[1];
        end
    end

    assign scl_s    = scl_ff[1];
    assign sda_s    = sda_ff[1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign sda_rise = sda_s & ~sda_h;
    assign sda_fall = ~sda_s & sda_h;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave with a 256x8 register file: 3-phase writes, 2-phase pointer set, 2-phase reads.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID  = 8'h42,
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic        XCLK,
    input  logic        RST_N,
    input  logic        SIO_C,
    inout  wire         SIO_D,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_strobe,
    output logic        busy,
    output sccb_state_t dbg_state
);

    localparam logic [3:0] TX_LAST = LAST_BIT_CNT - 4'd1;

    logic        scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall;
    logic        start_det, stop_det, byte_full;
    sccb_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  shreg, tx_sh, ptr;
    logic        rd_dir;
    logic        rx_shift, ptr_ld, reg_wr, tx_ld, tx_shift, busy_set, busy_clr, dir_ld;
    logic [7:0]  regfile [256];

    sccb_line_sync u_sync (
        .XCLK     (XCLK),
        .RST_N    (RST_N),
        .scl      (SIO_C),
        .sda      (SIO_D),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_rise (sda_rise),
        .sda_fall (sda_fall)
    );

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign byte_full = (cnt == LAST_BIT_CNT);

    // Push-pull only while shifting out read data; asynchronous reset releases at once.
    assign SIO_D     = (state == ST_RDATA) ? tx_sh[7] : 1'bz;
    assign dbg_state = state;

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rx_shift  = 1'b0;
        ptr_ld    = 1'b0;
        reg_wr    = 1'b0;
        tx_ld     = 1'b0;
        tx_shift  = 1'b0;
        busy_set  = 1'b0;
        busy_clr  = 1'b0;
        dir_ld    = 1'b0;
        if (stop_det) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            busy_clr  = 1'b1;
        end else if (start_det) begin
            state_nxt = ST_ID;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_ID, ST_SUB, ST_WDATA: begin
                    // Bits are taken on SCL rise; the phase closes on the fall after bit 8.
                    if (scl_rise && !byte_full) begin
                        rx_shift = 1'b1;
                        cnt_nxt  = cnt + 4'd1;
                    end else if (scl_fall && byte_full) begin
                        cnt_nxt = '0;
                        if (state == ST_ID) begin
                            if (id_match(shreg, DEV_ID)) begin
                                state_nxt = ST_ID_X;
                                busy_set  = 1'b1;
                                dir_ld    = 1'b1;
                            end else begin
                                state_nxt = ST_IGNORE;
                                busy_clr  = 1'b1;
                            end
                        end else if (state == ST_SUB) begin
                            ptr_ld    = 1'b1;
                            state_nxt = ST_SUB_X;
                        end else begin
                            reg_wr    = 1'b1;
                            state_nxt = ST_WDATA_X;
                        end
                    end
                end
                ST_ID_X: begin
                    if (scl_fall) begin
                        state_nxt = rd_dir ? ST_RDATA : ST_SUB;
                        tx_ld     = rd_dir;
                    end
                end
                ST_SUB_X: begin
                    if (scl_fall) state_nxt = ST_WDATA;
                end
                ST_WDATA_X, ST_RDATA_X: begin
                    if (scl_fall) state_nxt = ST_IGNORE;
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (cnt == TX_LAST) begin
                            state_nxt = ST_RDATA_X;
                            cnt_nxt   = '0;
                        end else begin
                            tx_shift = 1'b1;
                            cnt_nxt  = cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            shreg     <= '0;
            tx_sh     <= '0;
            ptr       <= '0;
            rd_dir    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
        end else begin
            wr_strobe <= reg_wr;
            rd_strobe <= tx_ld;
            if (rx_shift) shreg <= {shreg[6:0], sda_s};
            if (ptr_ld)   ptr   <= shreg;
            if (dir_ld)   rd_dir <= shreg[0];
            if (busy_clr)      busy <= 1'b0;
            else if (busy_set) busy <= 1'b1;
            if (reg_wr) begin
                wr_addr <= ptr;
                wr_data <= shreg;
            end
            if (tx_ld)         tx_sh <= regfile[ptr];
            else if (tx_shift) tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

    // The SCCB write is the later assignment, so it wins a same-cycle address clash.
    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 256; i++) regfile[i] <= REG_RST;
        end else begin
            if (cfg_we) regfile[cfg_addr] <= cfg_wdata;
            if (reg_wr) regfile[ptr] <= shreg;
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: vector table, corner sequences, randomized transactions.
module tb_sccb_responder;
    import sccb_pkg::*;

    localparam logic [7:0] DEV_ID  = 8'h42;
    localparam logic [7:0] REG_RST = 8'h00;
    localparam int HALF  = 100;
    localparam int SETUP = 70;
    localparam int HOLD  = 30;

    logic        XCLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SIO_C = 1'b1;
    logic        m_low = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;
    logic        wr_strobe, rd_strobe, busy;
    logic [7:0]  wr_addr, wr_data;
    sccb_state_t dbg_state;
    wire         SIO_D;

    pullup pu_sda (SIO_D);
    assign SIO_D = m_low ? 1'b0 : 1'bz;

    sccb_responder #(.DEV_ID(DEV_ID), .REG_RST(REG_RST)) dut (
        .XCLK      (XCLK),
        .RST_N     (RST_N),
        .SIO_C     (SIO_C),
        .SIO_D     (SIO_D),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 XCLK = ~XCLK;

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         bad_drive = 0;
    logic       busy_seen = 1'b0;
    logic       rd_window = 1'b0;
    logic [7:0] last_wa = '0;
    logic [7:0] last_wd = '0;

    // Reference model: transaction-level view of the register file and pointer.
    logic [7:0] mdl [256];
    logic [7:0] mptr;

    typedef struct {
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] data;
        logic       exp_wr;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t tbl [6];

    always @(negedge XCLK) begin
        if (wr_strobe) begin
            wr_cnt++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (rd_strobe) rd_cnt++;
        if (busy) busy_seen = 1'b1;
        if (!m_low && SIO_D == 1'b0 && !rd_window) bad_drive++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit addressed(input logic [7:0] id);
        return id[7:1] == DEV_ID[7:1];
    endfunction

    // ---------------- master driver tasks (open-drain SDA) ----------------
    task automatic m_start();
        m_low = 1'b0; SIO_C = 1'b1; #HALF;
        m_low = 1'b1; #HALF;
        SIO_C = 1'b0;
    endtask

    task automatic m_rstart();
        #HOLD  m_low = 1'b0;
        #SETUP SIO_C = 1'b1;
        #HALF  m_low = 1'b1;
        #HALF  SIO_C = 1'b0;
    endtask

    task automatic m_stop();
        #HOLD  m_low = 1'b1;
        #SETUP SIO_C = 1'b1;
        #HALF  m_low = 1'b0;
        #HALF;
    endtask

    task automatic send_bit(input logic b);
        #HOLD  m_low = ~b;
        #SETUP SIO_C = 1'b1;
        #HALF  SIO_C = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic read_bit(output logic v);
        #HOLD  m_low = 1'b0;
        #SETUP SIO_C = 1'b1;
        #50    v = SIO_D;
        #50    SIO_C = 1'b0;
    endtask

    task automatic tr_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data);
        m_start();
        send_byte(id);
        send_byte(sub);
        send_byte(data);
        m_stop();
        if (addressed(id)) begin
            mdl[sub] = data;
            mptr = sub;
        end
    endtask

    task automatic tr_set_ptr(input logic [7:0] sub);
        m_start();
        send_byte({DEV_ID[7:1], 1'b0});
        send_byte(sub);
        m_stop();
        mptr = sub;
    endtask

    task automatic tr_read(input logic [7:0] id, input bit with_sub, input logic [7:0] sub,
                           output logic [7:0] v, output logic na);
        m_start();
        if (with_sub) begin
            send_byte({DEV_ID[7:1], 1'b0});
            send_byte(sub);
            mptr = sub;
            m_rstart();
        end
        send_byte(id);
        rd_window = addressed(id);
        for (int i = 7; i >= 0; i--) read_bit(v[i]);
        #40 rd_window = 1'b0;
        read_bit(na);
        m_stop();
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge XCLK);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge XCLK);
        cfg_we = 1'b0;
        mdl[a] = d;
    endtask

    initial begin
        #800_000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] v;
        logic       na;
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] data;
        int         w0, r0, kind;
        bit         found;
        logic [7:0] bits76;

        tbl[0] = '{id: 8'h42, sub: 8'h12, data: 8'h80, exp_wr: 1'b1, exp_rd: 8'h80};
        tbl[1] = '{id: 8'h60, sub: 8'h12, data: 8'h55, exp_wr: 1'b0, exp_rd: 8'h80};
        tbl[2] = '{id: 8'h42, sub: 8'hFF, data: 8'hA5, exp_wr: 1'b1, exp_rd: 8'hA5};
        tbl[3] = '{id: 8'h42, sub: 8'h00, data: 8'hFF, exp_wr: 1'b1, exp_rd: 8'hFF};
        tbl[4] = '{id: 8'h61, sub: 8'h00, data: 8'h00, exp_wr: 1'b0, exp_rd: 8'hFF};
        tbl[5] = '{id: 8'h42, sub: 8'h12, data: 8'h01, exp_wr: 1'b1, exp_rd: 8'h01};
        for (int i = 0; i < 256; i++) mdl[i] = REG_RST;
        mptr = 8'h00;

        // Reset values
        repeat (5) @(negedge XCLK);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_rd_strobe", rd_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_sio_d", SIO_D, 1'b1);
        chk("rst_state", dbg_state, ST_IDLE);
        RST_N = 1'b1;
        repeat (5) @(negedge XCLK);

        // Vector table: write, then read the same address back
        for (int t = 0; t < 6; t++) begin
            w0 = wr_cnt; busy_seen = 1'b0; bad_drive = 0;
            tr_write(tbl[t].id, tbl[t].sub, tbl[t].data);
            chk($sformatf("tbl%0d_wr_cnt", t), wr_cnt - w0, {31'd0, tbl[t].exp_wr});
            chk($sformatf("tbl%0d_busy", t), busy_seen, tbl[t].exp_wr);
            chk($sformatf("tbl%0d_no_drive", t), bad_drive, 0);
            if (tbl[t].exp_wr) begin
                chk($sformatf("tbl%0d_wr_addr", t), last_wa, tbl[t].sub);
                chk($sformatf("tbl%0d_wr_data", t), last_wd, tbl[t].data);
            end
            tr_read({DEV_ID[7:1], 1'b1}, 1'b1, tbl[t].sub, v, na);
            chk($sformatf("tbl%0d_readback", t), v, tbl[t].exp_rd);
            chk($sformatf("tbl%0d_model", t), v, mdl[tbl[t].sub]);
        end

        // Preloaded register read through repeated START
        cfg_write(8'h0A, 8'h76);
        r0 = rd_cnt; bad_drive = 0;
        tr_read(8'h43, 1'b1, 8'h0A, v, na);
        bits76 = 8'b0111_0110;
        for (int i = 7; i >= 0; i--) chk($sformatf("rd76_bit%0d", i), v[i], bits76[i]);
        chk("rd76_strobe", rd_cnt - r0, 1);
        chk("rd76_na_released", na, 1'b1);
        chk("rd76_no_stray_drive", bad_drive, 0);

        // STOP after 4 SUB bits leaves the pointer alone
        m_start();
        send_byte(8'h42);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        m_stop();
        repeat (4) @(negedge XCLK);
        chk("abort_busy", busy, 1'b0);
        chk("abort_state", dbg_state, ST_IDLE);
        tr_read(8'h43, 1'b0, 8'h00, v, na);
        chk("abort_ptr_kept", v, 8'h76);
        w0 = wr_cnt;
        tr_write(8'h42, 8'h33, 8'hC3);
        chk("after_abort_wr", wr_cnt - w0, 1);
        tr_read(8'h43, 1'b1, 8'h33, v, na);
        chk("after_abort_rd", v, 8'hC3);

        // cfg_we and SCCB write to 0x20 in the same cycle
        m_start();
        send_byte(8'h42);
        send_byte(8'h20);
        data = 8'hAB;
        for (int i = 7; i >= 1; i--) send_bit(data[i]);
        #HOLD  m_low = ~data[0];
        #SETUP SIO_C = 1'b1;
        #HALF;
        cfg_we = 1'b1; cfg_addr = 8'h20; cfg_wdata = 8'h5A;
        SIO_C = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge XCLK);
            if (wr_strobe) found = 1'b1;
        end
        cfg_we = 1'b0;
        chk("clash_wr_seen", found, 1'b1);
        send_bit(1'b1);
        m_stop();
        mdl[8'h20] = 8'hAB;
        mptr = 8'h20;
        tr_read(8'h43, 1'b1, 8'h20, v, na);
        chk("clash_sccb_wins", v, 8'hAB);

        // Randomized transactions against the model
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 3);
            sub  = 8'($urandom_range(0, 255));
            data = 8'($urandom_range(0, 255));
            id   = 8'($urandom_range(0, 255));
            if (addressed(id)) id = id ^ 8'h80;
            if ($urandom_range(0, 3) != 0) id = {DEV_ID[7:1], 1'b0};
            w0 = wr_cnt; r0 = rd_cnt; bad_drive = 0;
            case (kind)
                0: begin
                    tr_write(id, sub, data);
                    chk($sformatf("rnd%0d_wr_cnt", n), wr_cnt - w0, addressed(id) ? 1 : 0);
                end
                1: begin
                    tr_set_ptr(sub);
                    chk($sformatf("rnd%0d_ptr_only", n), wr_cnt - w0, 0);
                end
                2: begin
                    id[0] = 1'b1;
                    tr_read(id, 1'b0, 8'h00, v, na);
                    chk($sformatf("rnd%0d_rd_data", n), v, addressed(id) ? mdl[mptr] : 8'hFF);
                    chk($sformatf("rnd%0d_rd_cnt", n), rd_cnt - r0, addressed(id) ? 1 : 0);
                end
                default: cfg_write(sub, data);
            endcase
            chk($sformatf("rnd%0d_no_drive", n), bad_drive, 0);
        end

        // Reset pulse while bit 3 of 0x76 (a driven 0) is on the bus
        cfg_write(8'h0A, 8'h76);
        m_start();
        send_byte(8'h42);
        send_byte(8'h0A);
        m_rstart();
        send_byte(8'h43);
        rd_window = 1'b1;
        for (int i = 7; i >= 4; i--) read_bit(v[i]);
        #50;
        chk("mid_rd_driving_b3", SIO_D, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_sio_d", SIO_D, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wr_strobe", wr_strobe, 1'b0);
        chk("mid_rst_rd_strobe", rd_strobe, 1'b0);
        chk("mid_rst_wr_addr", wr_addr, 8'h00);
        chk("mid_rst_wr_data", wr_data, 8'h00);
        rd_window = 1'b0;
        #29 RST_N = 1'b1;
        for (int i = 0; i < 256; i++) mdl[i] = REG_RST;
        mptr = 8'h00;
        busy_seen = 1'b0; bad_drive = 0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        m_stop();
        chk("post_rst_idle_busy", busy_seen, 1'b0);
        chk("post_rst_no_drive", bad_drive, 0);
        tr_read(8'h43, 1'b1, 8'h0A, v, na);
        chk("post_rst_reg_value", v, mdl[8'h0A]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 8'h42, meaning device write ID; bit 0 is ignored and only bits [7:1] are matched.
REQ-002 SHALL have parameter REG_RST, default 8'h00, meaning the reset value of every register-file entry.
REQ-003 SHALL have port XCLK  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port SIO_C  input  1  meaning SCCB clock from the master, asynchronous to XCLK.
REQ-006 SHALL have port SIO_D  inout  1  meaning SCCB data; released (1'bz) except while driving read data.
REQ-007 SHALL have ports cfg_we (input, 1), cfg_addr (input, 8) and cfg_wdata (input, 8) meaning the local register preload port.
REQ-008 SHALL have ports wr_strobe (output, 1), wr_addr (output, 8) and wr_data (output, 8) meaning an SCCB-side register write event.
REQ-009 SHALL have port rd_strobe  output  1  meaning a one-cycle pulse when a read byte is loaded for transmission.
REQ-010 SHALL have port busy  output  1  meaning high from START to STOP of an addressed transaction.

Function
REQ-011 SHALL pass SIO_C and SIO_D through 2-FF synchronizers plus one history FF each, and derive all edges from the synchronized values.
REQ-012 SHALL detect START as a synchronized SIO_D fall with SIO_C high, and STOP as a SIO_D rise with SIO_C high; both are honoured in every state.
REQ-013 SHALL sample SIO_D on the synchronized SIO_C rising edge, and SHALL change its SIO_D drive within 3 XCLK cycles of the SIO_C falling edge. The SCCB half-period is at least 8 XCLK.
REQ-014 SHALL implement the states IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X and IGNORE, with a 4-bit bit counter 0..8 per phase.
REQ-015 START in any state SHALL go to ID with the counter cleared; this covers a repeated START without a preceding STOP.
REQ-016 STOP in any state SHALL go to IDLE, release SIO_D and deassert busy.
REQ-017 In ID, after 8 bits are shifted in MSB-first: a mismatch of [7:1] against DEV_ID SHALL go to IGNORE; a match SHALL go to ID_X with the direction taken from bit 0.
REQ-018 After ID_X, write direction SHALL go to SUB and read direction SHALL go to RDATA.
REQ-019 SUB SHALL shift 8 bits into the address pointer, then pass through SUB_X to WDATA.
REQ-020 The address pointer SHALL persist across STOP and across repeated START, and SHALL NOT auto-increment.
REQ-021 In WDATA, after the 8th bit: regfile[ptr] SHALL be updated, wr_strobe SHALL pulse one cycle with wr_addr=ptr and wr_data=byte, then the state SHALL go to WDATA_X and then to IGNORE.
REQ-022 On entry to RDATA: the shifter SHALL load regfile[ptr] and rd_strobe SHALL pulse one cycle.
REQ-023 In RDATA, bit 7 SHALL be driven from the SIO_C fall that ends ID_X, with one bit per fall, MSB first, push-pull.
REQ-024 After the 8th read bit's SIO_C fall, SIO_D SHALL be released and the state SHALL go to RDATA_X (the master drives NA=1) and then to IGNORE.
REQ-025 The responder SHALL never drive during any don't-care bit (ID_X, SUB_X, WDATA_X, RDATA_X).
REQ-026 IGNORE SHALL discard clocks until START or STOP.
REQ-027 A cfg_we write SHALL take effect on the next XCLK edge; if an SCCB write to the same address lands in the same cycle, the SCCB write SHALL win.
REQ-028 A 2-phase write (ID, SUB, then STOP) SHALL only update the pointer.

Reset
REQ-029 Reset SHALL set: state=IDLE, counter=0, ptr=0, SIO_D released, wr_strobe=0, rd_strobe=0, busy=0, wr_addr=0, wr_data=0, every regfile entry=REG_RST, and synchronizers to 1.
REQ-030 Reset asserted mid-transaction SHALL abort it; after release the block SHALL stay in IDLE until the next START.

Structure
REQ-031 State encoding and the phase length (9) SHALL be placed in a shared sccb package, which CoreSCCB-side code may also use.
REQ-032 The synchronizer and edge detector SHALL be one sub-module, sccb_line_sync (2 lines in; sync values, rise and fall outputs); the remaining logic SHALL stay flat.

Verification
REQ-033 3-phase write ID 0x42, sub 0x12, data 0x80 -> one wr_strobe with addr 0x12 and data 0x80; regfile[0x12]=0x80; SIO_D never driven.
REQ-034 Preload regfile[0x0A]=0x76 via cfg; master sends ID 0x42, sub 0x0A, repeated START, ID 0x43 -> rd_strobe pulses; bits 0,1,1,1,0,1,1,0 are driven; SIO_D is released for NA.
REQ-035 ID 0x60 with write data -> IGNORE; no strobes; busy stays 0; register file unchanged.
REQ-036 STOP injected after 4 SUB bits -> IDLE; ptr unchanged; the next full transaction works.
REQ-037 RST_N pulsed low during RDATA bit 3 -> SIO_D released within the same cycle; all outputs at their reset values.
REQ-038 cfg_we and an SCCB write to 0x20 in the same cycle -> regfile[0x20] holds the SCCB value.
